mem_port_arbiter: RTL

Two-requester arbiter sharing the single memory/MMIO command port (28-bit address, 32-bit data, valid/ready handshake) between the instruction-side (port 0) and data-side (port 1) cache controllers. Requests use the same valid/rw/addr/wdata and ready protocol on both sides, so either cache can poll and access SPART registers (0x8000001 status, 0x8000000 data) or DDR2 without knowing about the other. Round-robin grant, one outstanding transaction at a time.

---
 rtl/mem_arb_pkg.sv | 36 +++
 rtl/mem_arb_watchdog.sv | 38 +++
 rtl/mem_port_arbiter.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the two-port memory arbiter.
// State encoding, the latched command record, the SPART register map and
// the default read word returned when the optional watchdog expires.
package mem_arb_pkg;

    // Arbiter FSM states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } arb_state_e;

    // Command captured from the granted requester at grant time.
    typedef struct packed {
        logic        rw;
        logic [27:0] addr;
        logic [31:0] wdata;
    } mem_cmd_t;

    // SPART register addresses reachable through the shared command port.
    localparam logic [27:0] SPART_DATA_ADDR   = 28'h8000000;
    localparam logic [27:0] SPART_STATUS_ADDR = 28'h8000001;

    // Read word handed back when a transaction is abandoned by the watchdog.
    localparam logic [31:0] TIMEOUT_DATA_DEFAULT = 32'hDEADBEEF;

    // Round-robin pick: on a tie the port that was not served last wins,
    // otherwise the only requesting port is chosen. 0 = port 0, 1 = port 1.
    function automatic logic pick_port(input logic v0, input logic v1, input logic last);
        if (v0 && v1) begin
            return ~last;
        end
        return v1;
    endfunction

endpackage : mem_arb_pkg

// File: rtl/mem_arb_watchdog.sv
// mem_arb_watchdog: cycle counter for the ISSUE state. The count sits at
// zero whenever the arbiter is outside ISSUE, so it restarts on every entry,
// and expire_o is high during the LIMIT-th consecutive ISSUE cycle.
module mem_arb_watchdog #(
    parameter int LIMIT = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic active_i,
    output logic expire_o
);

    localparam int          CNT_W    = $clog2(LIMIT) + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LIMIT - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Count ISSUE cycles; clear as soon as the arbiter leaves ISSUE.
    always_comb begin
        count_d = '0;
        if (active_i) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    // Counter register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expire_o = active_i && (count_q == LAST_CNT);

endmodule : mem_arb_watchdog

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory/MMIO command port between the
// instruction-side (port 0) and data-side (port 1) cache controllers.
// Round-robin grant, one outstanding transaction, IDLE -> ISSUE -> RESP.
// Optional feature: define MEM_ARB_TIMEOUT_EN to build the ISSUE watchdog
// that abandons a stalled transaction after TIMEOUT_CYCLES cycles.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int          TIMEOUT_CYCLES = 1024,
    parameter logic [31:0] TIMEOUT_DATA   = TIMEOUT_DATA_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        c0_valid,
    input  logic        c0_rw,
    input  logic [27:0] c0_addr,
    input  logic [31:0] c0_wdata,
    output logic [31:0] c0_rdata,
    output logic        c0_ready,

    input  logic        c1_valid,
    input  logic        c1_rw,
    input  logic [27:0] c1_addr,
    input  logic [31:0] c1_wdata,
    output logic [31:0] c1_rdata,
    output logic        c1_ready,

    output logic        mem_valid,
    output logic        mem_rw,
    output logic [27:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,

    output logic        timeout_err
);

    arb_state_e  state_q,  state_d;
    logic        last_q,   last_d;     // port served by the previous transaction
    logic        grant_q,  grant_d;    // port owning the current transaction
    mem_cmd_t    cmd_q,    cmd_d;
    logic [31:0] rdata0_q, rdata0_d;
    logic [31:0] rdata1_q, rdata1_d;

    mem_cmd_t    c0_cmd;
    mem_cmd_t    c1_cmd;
    logic        granted_valid;
    logic        expire;
    logic        timeout_fire;

    assign c0_cmd = '{rw: c0_rw, addr: c0_addr, wdata: c0_wdata};
    assign c1_cmd = '{rw: c1_rw, addr: c1_addr, wdata: c1_wdata};

    assign granted_valid = grant_q ? c1_valid : c0_valid;

    // A watchdog abandon only counts when the memory did not answer in the
    // same cycle; a real completion always takes priority.
    assign timeout_fire = (state_q == ISSUE) && expire && !mem_ready;

    // Next-state logic: grant, command capture, read-data capture, release.
    always_comb begin
        // NOTE: every target gets a default before the case so that no path
        // leaves a variable unassigned, which would infer a latch.
        state_d  = state_q;
        last_d   = last_q;
        grant_d  = grant_q;
        cmd_d    = cmd_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;

        case (state_q)
            IDLE: begin
                // Leave IDLE only once the previous completion has cleared.
                if ((c0_valid || c1_valid) && !mem_ready) begin
                    grant_d = pick_port(c0_valid, c1_valid, last_q);
                    cmd_d   = grant_d ? c1_cmd : c0_cmd;
                    state_d = ISSUE;
                end
            end

            ISSUE: begin
                if (mem_ready) begin
                    if (!cmd_q.rw) begin
                        if (grant_q) begin
                            rdata1_d = mem_rdata;
                        end else begin
                            rdata0_d = mem_rdata;
                        end
                    end
                    state_d = RESP;
                end else if (timeout_fire) begin
                    if (!cmd_q.rw) begin
                        if (grant_q) begin
                            rdata1_d = TIMEOUT_DATA;
                        end else begin
                            rdata0_d = TIMEOUT_DATA;
                        end
                    end
                    state_d = RESP;
                end
            end

            RESP: begin
                // Handshake closes only when the requester has dropped valid
                // and the memory has dropped ready in the same cycle.
                if (!granted_valid && !mem_ready) begin
                    last_d  = grant_q;
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Arbiter state registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge value of every other register.
        if (rst) begin
            state_q  <= IDLE;
            last_q   <= 1'b1;
            grant_q  <= 1'b0;
            cmd_q    <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            grant_q  <= grant_d;
            cmd_q    <= cmd_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

`ifdef MEM_ARB_TIMEOUT_EN
    logic timeout_err_q;

    mem_arb_watchdog #(
        .LIMIT    (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk      (clk),
        .rst      (rst),
        .active_i (state_q == ISSUE),
        .expire_o (expire)
    );

    // Sticky timeout flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            timeout_err_q <= 1'b0;
        end else if (timeout_fire) begin
            timeout_err_q <= 1'b1;
        end
    end

    assign timeout_err = timeout_err_q;
`else
    // No watchdog in this build: the expiry term is a constant false that
    // still references TIMEOUT_CYCLES, and ISSUE waits for mem_ready forever.
    assign expire      = (TIMEOUT_CYCLES < 0);
    assign timeout_err = 1'b0;
`endif

    // Downstream command is driven only during ISSUE and is zero otherwise.
    assign mem_valid = (state_q == ISSUE);
    assign mem_rw    = mem_valid & cmd_q.rw;
    assign mem_addr  = mem_valid ? cmd_q.addr  : '0;
    assign mem_wdata = mem_valid ? cmd_q.wdata : '0;

    // Completion goes to the granted port only.
    assign c0_ready = (state_q == RESP) && !grant_q;
    assign c1_ready = (state_q == RESP) &&  grant_q;

    assign c0_rdata = rdata0_q;
    assign c1_rdata = rdata1_q;

endmodule : mem_port_arbiter
